// File: rtl/dph_fork_arbiter.sv
// Purpose : round-robin fork arbiter for N dining philosophers; grants both adjacent forks atomically.
// Latency : req sampled at edge k -> WAIT; earliest grant (eat/grant_pulse high) at edge k+1; done frees forks after one edge.
// Backpr. : none; req is a level that may be withdrawn while waiting, done is a one-cycle pulse honoured only in EAT.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; every register returns to its idle value
//   req[N]       philosopher i hungry (level)
//   done[N]      philosopher i finished eating (pulse, ignored outside EAT)
//   eat[N]       philosopher i holds both of its forks (registered)
//   grant_pulse  one cycle high on the first eat cycle (registered)
//   fork_busy    fork j held by an eating neighbour (registered)
//   rr_ptr       highest-priority philosopher for the next scan (registered)
//
// Build option: define DPH_AGING_EN for per-philosopher wait counters, urgent-first
// arbitration and fork reservation, which bounds the wait of every philosopher.
module dph_fork_arbiter #(
    parameter int N        = 5,
    parameter int MAX_WAIT = 12,
    parameter int CW       = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] done,
    output logic [N-1:0] eat,
    output logic [N-1:0] grant_pulse,
    output logic [N-1:0] fork_busy,
    output logic [2:0]   rr_ptr
);

    localparam logic [1:0] ST_THINK = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_EAT   = 2'd2;

    logic [N-1:0][1:0] st;
    logic [N-1:0][1:0] st_nxt;
    logic [N-1:0]      cand;
    logic [N-1:0]      urgent;
    logic [N-1:0]      grant;
    logic [N-1:0]      claimed;
    logic [N-1:0]      blocked;
    logic [N-1:0]      eat_nxt;
    logic [N-1:0]      fork_nxt;
    logic [2:0]        rr_nxt;
    int                last_off;

    // Index arithmetic never exceeds 2N-1, so a single conditional subtract suffices.
    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    // A waiting philosopher that drops req this cycle is not a candidate: withdrawal beats grant.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cand[i] = (st[i] == ST_WAIT) && req[i];
        end
    end

`ifdef DPH_AGING_EN
    logic [N-1:0][CW-1:0] wait_cnt;

    // Counts cycles spent continuously in WAIT; saturates, clears whenever WAIT is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (st[i] == ST_WAIT && st_nxt[i] == ST_WAIT) begin
                    if (wait_cnt[i] != {CW{1'b1}}) begin
                        wait_cnt[i] <= wait_cnt[i] + CW'(1);
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            urgent[i] = (st[i] == ST_WAIT) && (wait_cnt[i] >= CW'(MAX_WAIT));
        end
    end
`else
    assign urgent = '0;

    logic unused_cfg;
    assign unused_cfg = ^{MAX_WAIT[0], CW[0]};
`endif

    // Arbitration against the registered fork_busy, so forks freed by done this cycle
    // stay unavailable until the next one. Pass 1 only sees urgent philosophers (none
    // without aging); forks of urgent philosophers it could not serve are reserved
    // so pass 2 cannot keep stealing them.
    always_comb begin
        int idx;
        int rgt;
        idx      = 0;
        rgt      = 0;
        claimed  = fork_busy;
        grant    = '0;
        last_off = -1;

        for (int off = 0; off < N; off++) begin
            idx = wrap(int'(rr_ptr) + off);
            rgt = wrap(idx + 1);
            if (cand[idx] && urgent[idx] && !claimed[idx] && !claimed[rgt]) begin
                grant[idx]   = 1'b1;
                claimed[idx] = 1'b1;
                claimed[rgt] = 1'b1;
                last_off     = off;
            end
        end

        blocked = claimed;
        for (int i = 0; i < N; i++) begin
            if (cand[i] && urgent[i] && !grant[i]) begin
                blocked[i]          = 1'b1;
                blocked[wrap(i + 1)] = 1'b1;
            end
        end

        for (int off = 0; off < N; off++) begin
            idx = wrap(int'(rr_ptr) + off);
            rgt = wrap(idx + 1);
            if (cand[idx] && !urgent[idx] && !blocked[idx] && !blocked[rgt]) begin
                grant[idx]   = 1'b1;
                blocked[idx] = 1'b1;
                blocked[rgt] = 1'b1;
                if (off > last_off) begin
                    last_off = off;
                end
            end
        end
    end

    // Priority moves just past the grant that came last in scan order.
    always_comb begin
        rr_nxt = rr_ptr;
        if (last_off >= 0) begin
            rr_nxt = 3'(wrap(int'(rr_ptr) + last_off + 1));
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            st_nxt[i] = st[i];
            case (st[i])
                ST_THINK: if (req[i]) st_nxt[i] = ST_WAIT;
                ST_WAIT: begin
                    if (!req[i])       st_nxt[i] = ST_THINK;
                    else if (grant[i]) st_nxt[i] = ST_EAT;
                end
                ST_EAT:   if (done[i]) st_nxt[i] = ST_THINK;
                default:  st_nxt[i] = ST_THINK;
            endcase
        end
    end

    // Fork j is used by philosopher j (left) and philosopher j-1 (right).
    always_comb begin
        for (int i = 0; i < N; i++) begin
            eat_nxt[i] = (st_nxt[i] == ST_EAT);
        end
        for (int j = 0; j < N; j++) begin
            fork_nxt[j] = eat_nxt[j] | eat_nxt[wrap(j + N - 1)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= {N{ST_THINK}};
            eat         <= '0;
            grant_pulse <= '0;
            fork_busy   <= '0;
            rr_ptr      <= '0;
        end else begin
            st          <= st_nxt;
            eat         <= eat_nxt;
            grant_pulse <= grant;
            fork_busy   <= fork_nxt;
            rr_ptr      <= rr_nxt;
        end
    end

endmodule

// File: tb/tb_dph_fork_arbiter.sv
// Bench for dph_fork_arbiter: directed vector table, randomized run against a
// queue-based model of the dining rules, and a starvation scenario for philosopher 1.
module tb_dph_fork_arbiter;

    localparam int N        = 5;
    localparam int MAX_WAIT = 12;
    localparam int CW       = 4;
    localparam int TH = 0, WT = 1, ET = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] eat;
    logic [N-1:0] grant_pulse;
    logic [N-1:0] fork_busy;
    logic [2:0]   rr_ptr;

    always #5 clk = ~clk;

    dph_fork_arbiter #(.N(N), .MAX_WAIT(MAX_WAIT), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .eat         (eat),
        .grant_pulse (grant_pulse),
        .fork_busy   (fork_busy),
        .rr_ptr      (rr_ptr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int           m_st[N];
    int           m_cnt[N];
    int           m_eat_len[N];
    int           m_rr;
    logic [N-1:0] m_gp;

    function automatic logic [N-1:0] m_eat_vec();
        logic [N-1:0] v = '0;
        for (int p = 0; p < N; p++) v[p] = (m_st[p] == ET);
        return v;
    endfunction

    function automatic logic [N-1:0] m_fork_vec();
        logic [N-1:0] v = '0;
        for (int p = 0; p < N; p++) if (m_st[p] == ET) begin v[p] = 1'b1; v[(p + 1) % N] = 1'b1; end
        return v;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
        bit fk[N];
        bit res[N];
        bit urg[N];
        bit got[N];
        int order[$];
        int far, last, p;
        if (r) begin
            for (int i = 0; i < N; i++) begin m_st[i] = TH; m_cnt[i] = 0; m_eat_len[i] = 0; end
            m_rr = 0;
            m_gp = '0;
            return;
        end
        for (int i = 0; i < N; i++) begin fk[i] = 0; got[i] = 0; urg[i] = 0; end
        for (int i = 0; i < N; i++) if (m_st[i] == ET) begin fk[i] = 1; fk[(i + 1) % N] = 1; end
        for (int k = 0; k < N; k++) begin
            p = (m_rr + k) % N;
            if (m_st[p] == WT && q[p]) order.push_back(p);
        end
`ifdef DPH_AGING_EN
        for (int i = 0; i < N; i++) urg[i] = (m_cnt[i] >= MAX_WAIT);
`endif
        foreach (order[k]) begin
            p = order[k];
            if (urg[p] && !fk[p] && !fk[(p + 1) % N]) begin
                got[p] = 1; fk[p] = 1; fk[(p + 1) % N] = 1;
            end
        end
        for (int i = 0; i < N; i++) res[i] = fk[i];
        foreach (order[k]) begin
            p = order[k];
            if (urg[p] && !got[p]) begin res[p] = 1; res[(p + 1) % N] = 1; end
        end
        foreach (order[k]) begin
            p = order[k];
            if (!urg[p] && !res[p] && !res[(p + 1) % N]) begin
                got[p] = 1; res[p] = 1; res[(p + 1) % N] = 1;
            end
        end
        far = -1; last = 0;
        for (int i = 0; i < N; i++) if (got[i] && ((i - m_rr + N) % N) > far) begin
            far = (i - m_rr + N) % N; last = i;
        end
        if (far >= 0) m_rr = (last + 1) % N;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == WT && q[i] && !got[i]) m_cnt[i] = (m_cnt[i] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt[i] + 1;
            else m_cnt[i] = 0;
            case (m_st[i])
                TH: if (q[i]) m_st[i] = WT;
                WT: if (!q[i]) m_st[i] = TH; else if (got[i]) m_st[i] = ET;
                default: if (d[i]) m_st[i] = TH;
            endcase
            m_eat_len[i] = (m_st[i] == ET) ? m_eat_len[i] + 1 : 0;
            m_gp[i] = got[i];
        end
    endtask

    task automatic tick(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
        reset = r; req = q; done = d;
        @(posedge clk);
        #1;
        model_step(r, q, d);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_eat"},  eat,         m_eat_vec());
        check({tag, "_gp"},   grant_pulse, m_gp);
        check({tag, "_fork"}, fork_busy,   m_fork_vec());
        check({tag, "_rr"},   rr_ptr,      m_rr);
        check({tag, "_excl"}, eat & {eat[0], eat[N-1:1]}, 0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] eat;
        logic [N-1:0] gp;
        logic [N-1:0] fb;
        logic [2:0]   rr;
    } vec_t;

    vec_t         tbl[23];
    logic [N-1:0] q, d;
    int           t_grant;

    initial begin
        reset = 1'b1; req = '0; done = '0;
        // reset with everyone hungry, then release
        tbl[0]  = '{1'b1, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd0};
        tbl[1]  = '{1'b1, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd0};
        tbl[2]  = '{1'b0, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd0};
        tbl[3]  = '{1'b0, 5'b11111, 5'b00000, 5'b00101, 5'b00101, 5'b01111, 3'd3};
        tbl[4]  = '{1'b0, 5'b11111, 5'b00000, 5'b00101, 5'b00000, 5'b01111, 3'd3};
        tbl[5]  = '{1'b0, 5'b11111, 5'b00101, 5'b00000, 5'b00000, 5'b00000, 3'd3};
        tbl[6]  = '{1'b0, 5'b11111, 5'b00000, 5'b01010, 5'b01010, 5'b11110, 3'd2};
        // reset while 1 and 3 eat
        tbl[7]  = '{1'b1, 5'b11111, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 3'd0};
        // single request from philosopher 0
        tbl[8]  = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd0};
        tbl[9]  = '{1'b0, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00011, 3'd1};
        tbl[10] = '{1'b0, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00011, 3'd1};
        tbl[11] = '{1'b0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 3'd1};
        tbl[12] = '{1'b0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 3'd1};
        // philosopher 3 withdraws while waiting
        tbl[13] = '{1'b0, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd1};
        tbl[14] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd1};
        tbl[15] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd1};
        // 1 eats, 2 waits on the shared fork, then is granted one edge after done[1]
        tbl[16] = '{1'b0, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd1};
        tbl[17] = '{1'b0, 5'b00110, 5'b00000, 5'b00010, 5'b00010, 5'b00110, 3'd2};
        tbl[18] = '{1'b0, 5'b00110, 5'b00000, 5'b00010, 5'b00000, 5'b00110, 3'd2};
        tbl[19] = '{1'b0, 5'b00110, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 3'd2};
        tbl[20] = '{1'b0, 5'b00100, 5'b00000, 5'b00100, 5'b00100, 5'b01100, 3'd3};
        tbl[21] = '{1'b0, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 3'd3};
        tbl[22] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd3};

        for (int k = 0; k < 23; k++) begin
            tick(tbl[k].rst, tbl[k].req, tbl[k].done);
            check($sformatf("vec%0d_eat", k),  eat,         tbl[k].eat);
            check($sformatf("vec%0d_gp", k),   grant_pulse, tbl[k].gp);
            check($sformatf("vec%0d_fork", k), fork_busy,   tbl[k].fb);
            check($sformatf("vec%0d_rr", k),   rr_ptr,      tbl[k].rr);
        end

        // ---------------- randomized run ----------------
        tick(1'b1, '0, '0);
        q = '0;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) q[b] = ~q[b];
                d[b] = ($urandom_range(0, 2) == 0);
            end
            tick($urandom_range(0, 99) == 0, q, d);
            compare_model($sformatf("rnd%0d", c));
        end

        // ---------------- neighbours 0 and 2 keep philosopher 1 hungry ----------------
        tick(1'b1, '0, '0);
        t_grant = -1;
        for (int c = 0; c < 40; c++) begin
            q = '0;
            q[0] = 1'b1;
            if (c >= 1) q[2] = 1'b1;
            if (c >= 3) q[1] = 1'b1;
            for (int b = 0; b < N; b++) d[b] = (m_st[b] == ET) && (m_eat_len[b] >= 2);
            tick(1'b0, q, d);
            compare_model($sformatf("age%0d", c));
            if (eat[1] && t_grant < 0 && c >= 3) t_grant = c;
        end
`ifdef DPH_AGING_EN
        check("aging_bound", (t_grant >= 0) && (t_grant - 3 <= MAX_WAIT + 3), 1'b1);
`else
        if (t_grant < 0) $display("note: philosopher 1 not granted within 40 cycles (aging disabled)");
        else $display("note: philosopher 1 waited %0d cycles (aging disabled)", t_grant - 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
